// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions used by the register-file writeback path.
// Widths, the hardwired $zero index, and the writeback record passed between producers.
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int WORD_W     = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [WORD_W-1:0]     data;
    } regwrite_t;

endpackage

// File: rtl/mips_fwd_match.sv
// Youngest-match search over the pending writeback entries for one decode read port.
// Entries are visited oldest to youngest so that the last hit found wins.
module mips_fwd_match
    import mips_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = WORD_W,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]             entry_valid,
    input  logic [DEPTH-1:0][ADDR_W-1:0] entry_addr,
    input  logic [DEPTH-1:0][DATA_W-1:0] entry_data,
    input  logic [PTR_W-1:0]             head,
    input  logic [ADDR_W-1:0]            src_addr,
    output logic                         hit,
    output logic [DATA_W-1:0]            data
);

    always_comb begin : search
        logic [PTR_W-1:0] idx;
        hit  = 1'b0;
        data = '0;
        idx  = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (src_addr != ADDR_W'(REG_ZERO) && entry_valid[idx] &&
                entry_addr[idx] == src_addr) begin
                hit  = 1'b1;
                data = entry_data[idx];
            end
        end
    end

endmodule

// File: rtl/mips_reg_write_queue.sv
// In-order writeback queue in front of the register-file write port.
// Drains one entry per granted cycle and exposes pending values to decode for bypassing.
module mips_reg_write_queue
    import mips_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = WORD_W,
    parameter int ADDR_W = REG_ADDR_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              wr_grant,
    output logic              write_enable,
    output logic [ADDR_W-1:0] dst_addr,
    output logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] src_addr_1,
    input  logic [ADDR_W-1:0] src_addr_2,
    output logic              fwd_hit_1,
    output logic [DATA_W-1:0] fwd_data_1,
    output logic              fwd_hit_2,
    output logic [DATA_W-1:0] fwd_data_2,
    output logic [CNT_W-1:0]  count,
    output logic              empty
);

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
    logic [DEPTH-1:0][DATA_W-1:0] data_q;
    logic [DEPTH-1:0]             valid_q;
    logic [PTR_W-1:0]             rd_ptr;
    logic [PTR_W-1:0]             wr_ptr;
    logic [CNT_W-1:0]             count_q;
    logic [CNT_W-1:0]             count_next;
    logic                         empty_q;
    logic                         push;
    logic                         pop;

    // Ready comes only from registered count, so a full queue never passes through.
    assign in_ready     = (count_q < FULL_COUNT);
    assign push         = in_valid && in_ready && (in_addr != ADDR_W'(REG_ZERO));
    assign pop          = write_enable;
    assign write_enable = !empty_q && wr_grant;
    assign dst_addr     = empty_q ? '0 : addr_q[rd_ptr];
    assign write_data   = empty_q ? '0 : data_q[rd_ptr];
    assign count        = count_q;
    assign empty        = empty_q;

    always_comb begin
        count_next = count_q;
        case ({push, pop})
            2'b10:   count_next = count_q + CNT_W'(1);
            2'b01:   count_next = count_q - CNT_W'(1);
            default: count_next = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            valid_q <= '0;
        end else begin
            if (push) begin
                wr_ptr          <= wr_ptr + PTR_W'(1);
                valid_q[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr          <= rd_ptr + PTR_W'(1);
                valid_q[rd_ptr] <= 1'b0;
            end
            count_q <= count_next;
            empty_q <= (count_next == '0);
        end
    end

    // NOTE: the payload array has no reset; valid_q and empty_q gate every use of it.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= in_addr;
            data_q[wr_ptr] <= in_data;
        end
    end

    mips_fwd_match #(
        .DEPTH (DEPTH),
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_fwd_1 (
        .entry_valid(valid_q),
        .entry_addr (addr_q),
        .entry_data (data_q),
        .head       (rd_ptr),
        .src_addr   (src_addr_1),
        .hit        (fwd_hit_1),
        .data       (fwd_data_1)
    );

    mips_fwd_match #(
        .DEPTH (DEPTH),
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_fwd_2 (
        .entry_valid(valid_q),
        .entry_addr (addr_q),
        .entry_data (data_q),
        .head       (rd_ptr),
        .src_addr   (src_addr_2),
        .hit        (fwd_hit_2),
        .data       (fwd_data_2)
    );

endmodule

// File: tb/tb_mips_reg_write_queue.sv
// Directed bench for mips_reg_write_queue: reset, drain order, full/backpressure,
// duplicate forwarding, $zero discard and mid-operation reset.
module tb_mips_reg_write_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_addr;
    logic [31:0] in_data;
    logic        wr_grant;
    logic        write_enable;
    logic [4:0]  dst_addr;
    logic [31:0] write_data;
    logic [4:0]  src_addr_1;
    logic [4:0]  src_addr_2;
    logic        fwd_hit_1;
    logic [31:0] fwd_data_1;
    logic        fwd_hit_2;
    logic [31:0] fwd_data_2;
    logic [2:0]  count;
    logic        empty;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mips_reg_write_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_addr     (in_addr),
        .in_data     (in_data),
        .wr_grant    (wr_grant),
        .write_enable(write_enable),
        .dst_addr    (dst_addr),
        .write_data  (write_data),
        .src_addr_1  (src_addr_1),
        .src_addr_2  (src_addr_2),
        .fwd_hit_1   (fwd_hit_1),
        .fwd_data_1  (fwd_data_1),
        .fwd_hit_2   (fwd_hit_2),
        .fwd_data_2  (fwd_data_2),
        .count       (count),
        .empty       (empty)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance past the next rising edge; inputs set afterwards apply to the next edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic offer(input logic [4:0] a, input logic [31:0] d);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
    endtask

    task automatic check_port(input string tag, input logic we, input logic [4:0] a,
                              input logic [31:0] d);
        check({tag, ".we"},   {31'd0, write_enable}, {31'd0, we});
        check({tag, ".addr"}, {27'd0, dst_addr},     {27'd0, a});
        check({tag, ".data"}, write_data,            d);
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_addr    = '0;
        in_data    = '0;
        wr_grant   = 1'b0;
        src_addr_1 = '0;
        src_addr_2 = '0;

        // 1: reset state
        step();
        step();
        reset = 1'b0;
        #1;
        check("rst.empty",    {31'd0, empty},     32'd1);
        check("rst.count",    {29'd0, count},     32'd0);
        check("rst.in_ready", {31'd0, in_ready},  32'd1);
        check("rst.hit1",     {31'd0, fwd_hit_1}, 32'd0);
        check("rst.hit2",     {31'd0, fwd_hit_2}, 32'd0);
        check_port("rst", 1'b0, 5'd0, 32'd0);

        // 2: single write, forwarded while pending, in-flight not forwarded
        wr_grant   = 1'b1;
        src_addr_1 = 5'd1;
        offer(5'd1, 32'd3);
        #1;
        check("t2.inflight_hit1", {31'd0, fwd_hit_1}, 32'd0);
        step();
        in_valid = 1'b0;
        #1;
        check_port("t2.drain", 1'b1, 5'd1, 32'd3);
        check("t2.hit1",  {31'd0, fwd_hit_1}, 32'd1);
        check("t2.data1", fwd_data_1,         32'd3);
        check("t2.count", {29'd0, count},     32'd1);
        step();
        #1;
        check("t2.empty", {31'd0, empty},     32'd1);
        check("t2.idle_we", {31'd0, write_enable}, 32'd0);
        check("t2.hit1_gone", {31'd0, fwd_hit_1}, 32'd0);

        // 3: fill to full, backpressure, then drain in order with refill
        wr_grant   = 1'b0;
        src_addr_1 = 5'd0;
        for (int i = 0; i < 4; i++) begin
            offer(5'd2 + 5'(i), 32'd10 + 32'(i));
            step();
        end
        offer(5'd6, 32'd14);
        #1;
        check("t3.full_count", {29'd0, count},    32'd4);
        check("t3.full_ready", {31'd0, in_ready}, 32'd0);
        step();
        #1;
        check("t3.held_count", {29'd0, count},    32'd4);
        check_port("t3.held", 1'b0, 5'd2, 32'd10);
        wr_grant = 1'b1;
        #1;
        check_port("t3.w0", 1'b1, 5'd2, 32'd10);
        step();
        #1;
        check("t3.after_pop_count", {29'd0, count},    32'd3);
        check("t3.after_pop_ready", {31'd0, in_ready}, 32'd1);
        check_port("t3.w1", 1'b1, 5'd3, 32'd11);
        step();
        in_valid = 1'b0;
        #1;
        check("t3.pushpop_count", {29'd0, count}, 32'd3);
        check_port("t3.w2", 1'b1, 5'd4, 32'd12);
        step();
        #1;
        check_port("t3.w3", 1'b1, 5'd5, 32'd13);
        step();
        #1;
        check_port("t3.w4", 1'b1, 5'd6, 32'd14);
        step();
        #1;
        check("t3.empty", {31'd0, empty}, 32'd1);
        check_port("t3.idle", 1'b0, 5'd0, 32'd0);

        // 4: duplicate addresses, youngest forwarded, written oldest first
        wr_grant = 1'b0;
        offer(5'd7, 32'd5);
        step();
        offer(5'd7, 32'd9);
        step();
        in_valid   = 1'b0;
        src_addr_2 = 5'd7;
        #1;
        check("t4.count", {29'd0, count},     32'd2);
        check("t4.hit2",  {31'd0, fwd_hit_2}, 32'd1);
        check("t4.data2", fwd_data_2,         32'd9);
        check("t4.hit1",  {31'd0, fwd_hit_1}, 32'd0);
        wr_grant = 1'b1;
        #1;
        check_port("t4.w0", 1'b1, 5'd7, 32'd5);
        step();
        #1;
        check_port("t4.w1", 1'b1, 5'd7, 32'd9);
        check("t4.data2_head", fwd_data_2, 32'd9);
        step();
        #1;
        check("t4.hit2_gone", {31'd0, fwd_hit_2}, 32'd0);
        check("t4.data2_gone", fwd_data_2,        32'd0);
        src_addr_2 = 5'd0;

        // 5: $zero writeback consumed but never stored or written
        src_addr_1 = 5'd0;
        offer(5'd0, 32'h0000_FFFF);
        #1;
        check("t5.ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        #1;
        check("t5.count", {29'd0, count},     32'd0);
        check("t5.empty", {31'd0, empty},     32'd1);
        check("t5.hit1",  {31'd0, fwd_hit_1}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            check("t5.no_we", {31'd0, write_enable}, 32'd0);
            step();
        end

        // 6: asynchronous reset mid-operation discards pending entries
        wr_grant = 1'b0;
        for (int i = 0; i < 3; i++) begin
            offer(5'd8 + 5'(i), 32'h100 + 32'(i));
            step();
        end
        in_valid   = 1'b0;
        src_addr_1 = 5'd8;
        src_addr_2 = 5'd10;
        #1;
        check("t6.count_pre", {29'd0, count},     32'd3);
        check("t6.hit1_pre",  {31'd0, fwd_hit_1}, 32'd1);
        check("t6.data2_pre", fwd_data_2,         32'h102);
        reset = 1'b1;
        #1;
        check("t6.count", {29'd0, count},     32'd0);
        check("t6.empty", {31'd0, empty},     32'd1);
        check("t6.hit1",  {31'd0, fwd_hit_1}, 32'd0);
        check("t6.hit2",  {31'd0, fwd_hit_2}, 32'd0);
        check("t6.data1", fwd_data_1,         32'd0);
        check_port("t6.rst", 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        reset    = 1'b0;
        wr_grant = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t6.no_we", {31'd0, write_enable}, 32'd0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
